// File: rtl/axis_serializer.sv
// Wide-to-narrow AXI-Stream serializer: one shift register plus one skid word, LSB beat first.
// Optional olast output is enabled by defining AXIS_SERIALIZER_LAST_EN.
module axis_serializer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    output logic [1:0]               size,
    input  logic [WIDTH*RATIO-1:0]   idata,
    input  logic                     ivalid,
    output logic                     iready,
    output logic [WIDTH-1:0]         odata,
    output logic                     ovalid,
    input  logic                     oready
`ifdef AXIS_SERIALIZER_LAST_EN
    ,
    output logic                     olast
`endif
);

    localparam int DW = WIDTH * RATIO;
    localparam int CW = $clog2(RATIO + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DW-1:0] shreg_reg;
    logic [DW-1:0] shreg_next;
    logic [DW-1:0] skid_reg;
    logic [DW-1:0] skid_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_dec;
    logic          full_reg;
    logic          full_next;
    logic          ovalid_reg;
    logic          iready_reg;
    logic          out_xfer;
    logic          in_xfer;

    // iready mirrors ~full_reg, so a skid reload and an input transfer never coincide.
    always_comb begin
        out_xfer   = ovalid_reg & oready;
        in_xfer    = ivalid & iready_reg;
        cnt_dec    = out_xfer ? (cnt_reg - CNT_ONE) : cnt_reg;
        shreg_next = out_xfer ? (shreg_reg >> WIDTH) : shreg_reg;
        cnt_next   = cnt_dec;
        skid_next  = skid_reg;
        full_next  = full_reg;
        if (cnt_dec == '0) begin
            if (full_reg) begin
                shreg_next = skid_reg;
                cnt_next   = CNT_FULL;
                full_next  = 1'b0;
            end else if (in_xfer) begin
                shreg_next = idata;
                cnt_next   = CNT_FULL;
            end
        end else if (in_xfer) begin
            skid_next = idata;
            full_next = 1'b1;
        end
    end

    // Datapath words carry no reset; they are only observed while ovalid is high.
    always_ff @(posedge clock) begin
        shreg_reg <= shreg_next;
        skid_reg  <= skid_next;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_reg    <= '0;
            full_reg   <= 1'b0;
            ovalid_reg <= 1'b0;
            iready_reg <= 1'b1;
        end else begin
            cnt_reg    <= cnt_next;
            full_reg   <= full_next;
            ovalid_reg <= (cnt_next != '0);
            iready_reg <= ~full_next;
        end
    end

`ifdef AXIS_SERIALIZER_LAST_EN
    logic olast_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            olast_reg <= 1'b0;
        end else begin
            olast_reg <= (cnt_next == CNT_ONE);
        end
    end

    assign olast = olast_reg;
`endif

    assign odata  = shreg_reg[WIDTH-1:0];
    assign ovalid = ovalid_reg;
    assign iready = iready_reg;
    assign size   = full_reg ? 2'd2 : (ovalid_reg ? 2'd1 : 2'd0);

endmodule
